// File: rtl/dmi_jtag_dr_ctrl.sv
// rtl/dmi_jtag_dr_ctrl.sv - JTAG DMI data register and debug module request/response sequencer
module dmi_jtag_dr_ctrl #(
    parameter int unsigned AbitsWidth = 7
) (
    input  logic                  tck_i,
    input  logic                  trst_ni,
    input  logic                  test_logic_reset_i,
    input  logic                  dmi_access_i,
    input  logic                  capture_dr_i,
    input  logic                  shift_dr_i,
    input  logic                  update_dr_i,
    input  logic                  dmi_tdi_i,
    output logic                  dmi_tdo_o,
    input  logic                  dmi_reset_i,
    output logic [1:0]            dmi_error_o,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output logic [AbitsWidth-1:0] dmi_req_addr_o,
    output logic [1:0]            dmi_req_op_o,
    output logic [31:0]           dmi_req_data_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  logic [31:0]           dmi_resp_data_i,
    input  logic [1:0]            dmi_resp_op_i
);

    localparam int unsigned DrWidth = AbitsWidth + 34;

    typedef enum logic [2:0] {
        Idle           = 3'd0,
        Read           = 3'd1,
        WaitReadValid  = 3'd2,
        Write          = 3'd3,
        WaitWriteValid = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [DrWidth-1:0]    dr_q, dr_d;
    logic [AbitsWidth-1:0] address_q, address_d;
    logic [31:0]           data_q, data_d;
    logic [1:0]            error_q, error_d;
    logic                  busy;

    assign busy           = (state_q != Idle);
    assign dmi_tdo_o      = dr_q[0];
    assign dmi_error_o    = error_q;
    assign dmi_req_addr_o = address_q;
    assign dmi_req_data_o = data_q;

    always_comb begin
        state_d          = state_q;
        dr_d             = dr_q;
        address_d        = address_q;
        data_d           = data_q;
        error_d          = error_q;
        dmi_req_valid_o  = 1'b0;
        dmi_req_op_o     = 2'd0;
        dmi_resp_ready_o = 1'b0;

        case (state_q)
            Idle: ;
            Read: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = 2'd1;
                if (dmi_req_ready_i) state_d = WaitReadValid;
            end
            Write: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = 2'd2;
                if (dmi_req_ready_i) state_d = WaitWriteValid;
            end
            WaitReadValid, WaitWriteValid: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) begin
                    if (state_q == WaitReadValid) data_d = dmi_resp_data_i;
                    if (dmi_resp_op_i != 2'd0 && error_q == 2'd0) error_d = 2'd2;
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase

        // TAP-side strobes; a busy report from the host side outranks a same-cycle response failure
        if (test_logic_reset_i) begin
            dr_d    = '0;
            error_d = 2'd0;
        end else if (dmi_access_i) begin
            if (capture_dr_i) begin
                dr_d = {address_q, data_q, error_q};
                if (busy) begin
                    dr_d[1:0] = 2'd3;
                    error_d   = 2'd3;
                end
            end else if (shift_dr_i) begin
                dr_d = {dmi_tdi_i, dr_q[DrWidth-1:1]};
            end else if (update_dr_i && error_q == 2'd0) begin
                if (busy) begin
                    error_d = 2'd3;
                end else if (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2) begin
                    address_d = dr_q[DrWidth-1:34];
                    data_d    = dr_q[33:2];
                    state_d   = (dr_q[1:0] == 2'd1) ? Read : Write;
                end
            end
        end

        if (dmi_reset_i) error_d = 2'd0;
    end

    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            state_q   <= Idle;
            dr_q      <= '0;
            address_q <= '0;
            data_q    <= '0;
            error_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            dr_q      <= dr_d;
            address_q <= address_d;
            data_q    <= data_d;
            error_q   <= error_d;
        end
    end

endmodule
